// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its wait counter.
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // An access is bad when it is not word aligned or its word index is past the array end.
  function automatic logic addr_err(input logic [31:0] a, input int unsigned words);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(words));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bus between the pipeline and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid_m;
  logic        req_write_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        stall_req;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid_m, req_write_m, addr_m, wdata_m,
    input  stall_req, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid_m, req_write_m, addr_m, wdata_m,
    output stall_req, resp_valid, rdata, err
  );

endinterface

// File: rtl/dmem_responder_wait_counter.sv
// Loadable down-counter with a zero flag; shared by the data and instruction responders.
module wait_counter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits WAIT_STATES cycles,
// then produces a single registered response cycle while the pipeline is released.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int                AW      = $clog2(MEM_WORDS);
  localparam bit                NO_WAIT = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0]  WS_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};

  dmem_state_t state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [MEM_WORDS];

  logic          accept_s;
  logic          cnt_zero_s;
  logic          to_resp_s;
  logic [31:0]   eff_addr_s;
  logic          eff_write_s;
  logic          eff_err_s;
  logic [AW-1:0] eff_idx_s;
  logic          commit_s;

  // With no wait states the response is formed from the live inputs in the accept cycle.
  always_comb begin
    accept_s    = (state_q == ST_IDLE) && bus.req_valid_m;
    eff_addr_s  = accept_s ? bus.addr_m      : addr_q;
    eff_write_s = accept_s ? bus.req_write_m : write_q;
    eff_err_s   = addr_err(eff_addr_s, MEM_WORDS);
    eff_idx_s   = eff_addr_s[AW+1:2];
    to_resp_s   = (accept_s && NO_WAIT) || ((state_q == ST_BUSY) && cnt_zero_s);
    commit_s    = (state_q == ST_RESP) && write_q && !err_q;
  end

  wait_counter u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept_s && !NO_WAIT),
    .load_val_i (WS_LOAD),
    .dec_i      ((state_q == ST_BUSY) && !cnt_zero_s),
    .zero_o     (cnt_zero_s)
  );

  // Control FSM, request capture and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= to_resp_s;
      err_q        <= to_resp_s && eff_err_s;
      rdata_q      <= (to_resp_s && !eff_err_s && !eff_write_s) ? mem_q[eff_idx_s] : 32'd0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            addr_q  <= bus.addr_m;
            wdata_q <= bus.wdata_m;
            write_q <= bus.req_write_m;
            state_q <= NO_WAIT ? ST_RESP : ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_zero_s) begin
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data array is deliberately not reset; a store lands on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (commit_s && !reset) begin
      mem_q[addr_q[AW+1:2]] <= wdata_q;
    end
  end

  assign bus.stall_req  = accept_s || (state_q == ST_BUSY);
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with two and zero wait states.
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.MEM_WORDS(64), .WAIT_STATES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  dmem_responder #(.MEM_WORDS(64), .WAIT_STATES(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access on DUT A; lat counts cycles after the accept edge until resp_valid (-1 on timeout).
  task automatic run_a(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
    bus_a.req_valid_m = 1'b1;
    bus_a.req_write_m = wr;
    bus_a.addr_m      = a;
    bus_a.wdata_m     = d;
    lat = -1;
    rd  = 32'd0;
    e   = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      if (bus_a.resp_valid === 1'b1) begin
        lat = i;
        rd  = bus_a.rdata;
        e   = bus_a.err;
        break;
      end
      @(posedge clk); #1;
    end
    bus_a.req_valid_m = 1'b0;
    @(posedge clk); #1;
  endtask

  // One access on DUT B, same protocol as run_a.
  task automatic run_b(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic e);
    bus_b.req_valid_m = 1'b1;
    bus_b.req_write_m = wr;
    bus_b.addr_m      = a;
    bus_b.wdata_m     = d;
    lat = -1;
    rd  = 32'd0;
    e   = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      if (bus_b.resp_valid === 1'b1) begin
        lat = i;
        rd  = bus_b.rdata;
        e   = bus_b.err;
        break;
      end
      @(posedge clk); #1;
    end
    bus_b.req_valid_m = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_a.resp_valid !== 1'b0 || bus_a.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp_err: resp_valid=%b err=%b required 0 0", bus_a.resp_valid, bus_a.err);
    end
    checks++;
    if (bus_a.rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 00000000", bus_a.rdata);
    end
    checks++;
    if (bus_a.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_idle: got %b required 0", bus_a.stall_req);
    end
    bus_a.req_valid_m = 1'b1;
    #1;
    checks++;
    if (bus_a.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_req: got %b required 1", bus_a.stall_req);
    end
    bus_a.req_valid_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic e;
    run_a(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
    checks++;
    if (lat !== 3 || e !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL store_0x10: lat=%0d err=%b rdata=%h required 3 0 00000000", lat, e, rd);
    end
    run_a(1'b0, 32'h10, 32'h0, lat, rd, e);
    checks++;
    if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_0x10: lat=%0d err=%b rdata=%h required 3 0 deadbeef", lat, e, rd);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic e;
    run_a(1'b1, 32'h13, 32'h11111111, lat, rd, e);
    checks++;
    if (lat !== 3 || e !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL store_0x13: lat=%0d err=%b rdata=%h required 3 1 00000000", lat, e, rd);
    end
    run_a(1'b0, 32'h10, 32'h0, lat, rd, e);
    checks++;
    if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_after_misaligned: err=%b rdata=%h required 0 deadbeef", e, rd);
    end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic e;
    run_a(1'b0, 32'h100, 32'h0, lat, rd, e);
    checks++;
    if (lat !== 3 || e !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL load_0x100: lat=%0d err=%b rdata=%h required 3 1 00000000", lat, e, rd);
    end
    run_a(1'b1, 32'hFC, 32'hA5A5A5A5, lat, rd, e);
    run_a(1'b0, 32'hFC, 32'h0, lat, rd, e);
    checks++;
    if (e !== 1'b0 || rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL load_0xFC_last_word: err=%b rdata=%h required 0 a5a5a5a5", e, rd);
    end
  endtask

  task automatic test_reset_busy();
    int lat; logic [31:0] rd; logic e; int seen;
    run_a(1'b1, 32'h20, 32'hCAFE0001, lat, rd, e);
    bus_a.req_valid_m = 1'b1;
    bus_a.req_write_m = 1'b1;
    bus_a.addr_m      = 32'h20;
    bus_a.wdata_m     = 32'h12345678;
    @(posedge clk); #1;
    checks++;
    if (bus_a.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL busy_stall: got %b required 1", bus_a.stall_req);
    end
    bus_a.req_valid_m = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (bus_a.stall_req !== 1'b0 || bus_a.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_busy: stall=%b resp_valid=%b required 0 0", bus_a.stall_req, bus_a.resp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus_a.resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL dropped_access_resp: got %0d responses required 0", seen);
    end
    run_a(1'b0, 32'h20, 32'h0, lat, rd, e);
    checks++;
    if (e !== 1'b0 || rd !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL load_0x20_after_reset: err=%b rdata=%h required 0 cafe0001", e, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_stall; logic exp_resp; int resps;
    resps = 0;
    bus_a.req_valid_m = 1'b1;
    bus_a.req_write_m = 1'b0;
    bus_a.addr_m      = 32'h10;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_stall = ((i % 4) != 3);
      exp_resp  = ((i % 4) == 3);
      checks++;
      if (bus_a.stall_req !== exp_stall || bus_a.resp_valid !== exp_resp) begin
        errors++;
        $display("FAIL b2b_cycle%0d: stall=%b resp_valid=%b required %b %b", i,
                 bus_a.stall_req, bus_a.resp_valid, exp_stall, exp_resp);
      end
      if (bus_a.resp_valid === 1'b1) resps++;
      @(posedge clk); #1;
    end
    bus_a.req_valid_m = 1'b0;
    checks++;
    if (resps !== 3) begin
      errors++;
      $display("FAIL b2b_resp_count: got %0d required 3", resps);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_wait();
    int lat; logic [31:0] rd; logic e;
    run_b(1'b1, 32'h8, 32'h0BADF00D, lat, rd, e);
    checks++;
    if (lat !== 1 || e !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL nowait_store: lat=%0d err=%b rdata=%h required 1 0 00000000", lat, e, rd);
    end
    bus_b.req_valid_m = 1'b1;
    bus_b.req_write_m = 1'b0;
    bus_b.addr_m      = 32'h8;
    #1;
    checks++;
    if (bus_b.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL nowait_accept_stall: got %b required 1", bus_b.stall_req);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_b.resp_valid !== 1'b1 || bus_b.stall_req !== 1'b0 || bus_b.rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL nowait_resp: resp_valid=%b stall=%b rdata=%h required 1 0 0badf00d",
               bus_b.resp_valid, bus_b.stall_req, bus_b.rdata);
    end
    bus_b.req_valid_m = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_b.resp_valid !== 1'b0 || bus_b.rdata !== 32'd0 || bus_b.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL nowait_after_resp: resp_valid=%b rdata=%h stall=%b required 0 00000000 0",
               bus_b.resp_valid, bus_b.rdata, bus_b.stall_req);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.req_valid_m = 1'b0; bus_a.req_write_m = 1'b0; bus_a.addr_m = 32'd0; bus_a.wdata_m = 32'd0;
    bus_b.req_valid_m = 1'b0; bus_b.req_write_m = 1'b0; bus_b.addr_m = 32'd0; bus_b.wdata_m = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_misaligned();
    test_range();
    test_reset_busy();
    test_back_to_back();
    test_no_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
